// File: rtl/clock_manager_core.sv
// Counter-based clock manager: lock sequencing, divided system clock family,
// phase-delayed SRAM clock and lock-gated copies of the crystal clock.
`timescale 1ns/1ps

module clock_manager_core #(
   parameter int LOCK_CYCLES      = 16,
   parameter int SRAM_LOCK_CYCLES = 8,
   parameter int SLOW_DIV         = 4,
   parameter int SRAM_PHASE       = 1
) (
   input  logic       input_clk,
   input  logic       input_clk_stable,
   output logic       modified_clock,
   output logic       modified_clock_inv,
   output logic       modified_clock_div_by_two,
   output logic       modified_clock_fast,
   output logic       modified_clock_fast_inv,
   output logic       modified_clock_sram,
   output logic       dcm_locked,
   output logic       dcm_locked_sram,
   output logic [7:0] modified_clock_period
);

   localparam logic [15:0] LOCK_LAST   = 16'(LOCK_CYCLES - 1);
   localparam logic [7:0]  SRAM_LAST   = 8'(SRAM_LOCK_CYCLES - 1);
   localparam logic [7:0]  CNT_LAST    = 8'(SLOW_DIV - 1);
   localparam logic [7:0]  HIGH_CYCLES = 8'(SLOW_DIV / 2);

   typedef enum logic [1:0] {
      ST_WAIT_LOCK,
      ST_WAIT_SRAM,
      ST_LOCKED
   } lock_state_t;

   lock_state_t state, state_next;
   logic [15:0] lock_cnt, lock_cnt_next;
   logic [7:0]  sram_cnt, sram_cnt_next;
   logic        locked_next, locked_sram_next;

   logic [7:0]  cnt, cnt_next;
   logic        clock_next, clock_inv_next, div_next;
   logic        fast_en;
   logic        sram_tap;

   // Lock sequencer: main lock first, then the SRAM lock counts from there.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_next    = state;
      lock_cnt_next = lock_cnt;
      sram_cnt_next = sram_cnt;
      case (state)
         ST_WAIT_LOCK: begin
            if (lock_cnt == LOCK_LAST) state_next = ST_WAIT_SRAM;
            else                       lock_cnt_next = lock_cnt + 16'd1;
         end
         ST_WAIT_SRAM: begin
            if (sram_cnt == SRAM_LAST) state_next = ST_LOCKED;
            else                       sram_cnt_next = sram_cnt + 8'd1;
         end
         default: state_next = ST_LOCKED;
      endcase
      locked_next      = (state_next != ST_WAIT_LOCK);
      locked_sram_next = (state_next == ST_LOCKED);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge input_clk or negedge input_clk_stable) begin
      if (!input_clk_stable) begin
         state           <= ST_WAIT_LOCK;
         lock_cnt        <= '0;
         sram_cnt        <= '0;
         dcm_locked      <= 1'b0;
         dcm_locked_sram <= 1'b0;
      end else begin
         state           <= state_next;
         lock_cnt        <= lock_cnt_next;
         sram_cnt        <= sram_cnt_next;
         dcm_locked      <= locked_next;
         dcm_locked_sram <= locked_sram_next;
      end
   end

   // Divider: the div-by-two flop toggles exactly when modified_clock is about to rise.
   always_comb begin
      cnt_next   = '0;
      clock_next = 1'b0;
      div_next   = 1'b0;
      if (dcm_locked) begin
         cnt_next   = (cnt == CNT_LAST) ? 8'd0 : cnt + 8'd1;
         clock_next = (cnt < HIGH_CYCLES);
         div_next   = (cnt == 8'd0) ? ~modified_clock_div_by_two : modified_clock_div_by_two;
      end
      clock_inv_next = locked_next & ~clock_next;
   end

   always_ff @(posedge input_clk or negedge input_clk_stable) begin
      if (!input_clk_stable) begin
         cnt                       <= '0;
         modified_clock_period     <= '0;
         modified_clock            <= 1'b0;
         modified_clock_inv        <= 1'b0;
         modified_clock_div_by_two <= 1'b0;
      end else begin
         cnt                       <= cnt_next;
         modified_clock_period     <= cnt;
         modified_clock            <= clock_next;
         modified_clock_inv        <= clock_inv_next;
         modified_clock_div_by_two <= div_next;
      end
   end

   generate
      if (SRAM_PHASE == 0) begin : g_sram_direct
         assign sram_tap = modified_clock;
      end else begin : g_sram_delay
         logic [SRAM_PHASE-1:0] sram_pipe;
         always_ff @(posedge input_clk or negedge input_clk_stable) begin
            if (!input_clk_stable) begin
               sram_pipe <= '0;
            end else begin
               sram_pipe[0] <= modified_clock;
               for (int i = 1; i < SRAM_PHASE; i++) sram_pipe[i] <= sram_pipe[i-1];
            end
         end
         assign sram_tap = sram_pipe[SRAM_PHASE-1];
      end
   endgenerate

   assign modified_clock_sram = sram_tap & dcm_locked_sram;

   // Enable changes only while input_clk is low, so the gated clock never emits a runt pulse.
   always_ff @(negedge input_clk or negedge input_clk_stable) begin
      if (!input_clk_stable) fast_en <= 1'b0;
      else                   fast_en <= dcm_locked;
   end

   assign modified_clock_fast     = input_clk & fast_en;
   assign modified_clock_fast_inv = ~input_clk & fast_en;

endmodule

// File: tb/tb_clock_manager_core.sv
// Self-checking bench for clock_manager_core: per-cycle comparison against an
// edge-count model plus literal timing points from the lock/divider sequence.
`timescale 1ns/1ps

module tb_clock_manager_core;

   localparam int L = 16;
   localparam int S = 8;
   localparam int D = 4;
   localparam int P = 1;

   logic       input_clk;
   logic       input_clk_stable;
   logic       modified_clock;
   logic       modified_clock_inv;
   logic       modified_clock_div_by_two;
   logic       modified_clock_fast;
   logic       modified_clock_fast_inv;
   logic       modified_clock_sram;
   logic       dcm_locked;
   logic       dcm_locked_sram;
   logic [7:0] modified_clock_period;

   int errors = 0;
   int checks = 0;
   int k      = 0;   // rising edges seen since the last reset release
   realtime mc_rise[$];
   realtime mc_fall[$];
   realtime div_rise[$];

   clock_manager_core #(
      .LOCK_CYCLES(L), .SRAM_LOCK_CYCLES(S), .SLOW_DIV(D), .SRAM_PHASE(P)
   ) dut (
      .input_clk                (input_clk),
      .input_clk_stable         (input_clk_stable),
      .modified_clock           (modified_clock),
      .modified_clock_inv       (modified_clock_inv),
      .modified_clock_div_by_two(modified_clock_div_by_two),
      .modified_clock_fast      (modified_clock_fast),
      .modified_clock_fast_inv  (modified_clock_fast_inv),
      .modified_clock_sram      (modified_clock_sram),
      .dcm_locked               (dcm_locked),
      .dcm_locked_sram          (dcm_locked_sram),
      .modified_clock_period    (modified_clock_period)
   );

   initial begin
      input_clk = 1'b0;
      forever #5 input_clk = ~input_clk;
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   // Model: outputs as a function of the number of rising edges since release.
   function automatic logic mc_at(int n);
      if (n < L + 1) return 1'b0;
      return ((n - L - 1) % D) < (D / 2);
   endfunction

   function automatic logic [31:0] period_at(int n);
      if (n < L + 1) return 0;
      return 32'((n - L - 1) % D);
   endfunction

   function automatic logic div_at(int n);
      if (n < L + 1) return 1'b0;
      return (((n - L - 1) / D) % 2) == 0;
   endfunction

   task automatic check_all(input logic clk_high);
      logic lk, lks;
      lk  = input_clk_stable && (k >= L);
      lks = input_clk_stable && (k >= L + S);
      check("dcm_locked",      32'(dcm_locked),      32'(lk));
      check("dcm_locked_sram", 32'(dcm_locked_sram), 32'(lks));
      check("mc",     32'(modified_clock),            32'(input_clk_stable && mc_at(k)));
      check("mc_inv", 32'(modified_clock_inv),        32'(lk && !mc_at(k)));
      check("div2",   32'(modified_clock_div_by_two), 32'(input_clk_stable && div_at(k)));
      check("period", 32'(modified_clock_period),     input_clk_stable ? period_at(k) : 32'd0);
      check("sram",   32'(modified_clock_sram),       32'(lks && mc_at(k - P)));
      if (clk_high) begin
         check("fast_hi",     32'(modified_clock_fast),     32'(input_clk_stable && (k - 1 >= L)));
         check("fast_inv_hi", 32'(modified_clock_fast_inv), 32'd0);
      end else begin
         check("fast_lo",     32'(modified_clock_fast),     32'd0);
         check("fast_inv_lo", 32'(modified_clock_fast_inv), 32'(lk));
      end
   endtask

   initial begin
      forever begin
         @(posedge input_clk);
         if (input_clk_stable) k++;
         else                  k = 0;
         #2 check_all(1'b1);
         @(negedge input_clk);
         if (!input_clk_stable) k = 0;
         #2 check_all(1'b0);
      end
   end

   always @(posedge modified_clock)            if (input_clk_stable) mc_rise.push_back($realtime);
   always @(negedge modified_clock)            if (input_clk_stable) mc_fall.push_back($realtime);
   always @(posedge modified_clock_div_by_two) if (input_clk_stable) div_rise.push_back($realtime);

   initial begin
      input_clk_stable = 1'b0;
      #100;
      check("reset_locked", 32'(dcm_locked), 32'd0);
      check("reset_period", 32'(modified_clock_period), 32'd0);
      #100 input_clk_stable = 1'b1;                    // t=200
      #147 check("pre_lock", 32'(dcm_locked), 32'd0);  // t=347
      #10;                                             // t=357
      check("lock_at_355", 32'(dcm_locked), 32'd1);
      check("fast_still_gated", 32'(modified_clock_fast), 32'd0);
      #10;                                             // t=367
      check("fast_first_pulse", 32'(modified_clock_fast), 32'd1);
      check("mc_first_high", 32'(modified_clock), 32'd1);
      check("div2_first_high", 32'(modified_clock_div_by_two), 32'd1);
      #60 check("pre_sram_lock", 32'(dcm_locked_sram), 32'd0);   // t=427
      #10 check("sram_lock_435", 32'(dcm_locked_sram), 32'd1);   // t=437
      #163 input_clk_stable = 1'b0;                    // t=600
      #1;
      check("midrst_locked", 32'(dcm_locked), 32'd0);
      check("midrst_sram",   32'(dcm_locked_sram), 32'd0);
      check("midrst_inv",    32'(modified_clock_inv), 32'd0);
      check("midrst_fast_inv", 32'(modified_clock_fast_inv), 32'd0);
      #29 input_clk_stable = 1'b1;                     // t=630
      #147 check("relock_early", 32'(dcm_locked), 32'd0);  // t=777
      #10  check("relock_785",   32'(dcm_locked), 32'd1);  // t=787
      #213;                                            // t=1000
      if (mc_rise.size() >= 2 && mc_fall.size() >= 1 && div_rise.size() >= 2) begin
         check("mc_first_rise_time", 32'(int'(mc_rise[0])), 32'd365);
         check("mc_period_ns", 32'(int'(mc_rise[1] - mc_rise[0])), 32'd40);
         check("mc_high_ns",   32'(int'(mc_fall[0] - mc_rise[0])), 32'd20);
         check("div2_period_ns", 32'(int'(div_rise[1] - div_rise[0])), 32'd80);
      end else begin
         check("edge_capture_count", 32'(mc_rise.size()), 32'd2);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
